// File: rtl/per_rst_pkg.sv
// per_rst_pkg: shared state encoding and counter-width helper for the soft-reset sequencer.
package per_rst_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLK_REQ = 2'd1,
    ASSERT  = 2'd2,
    RELEASE = 2'd3
  } state_e;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/per_sft_rst_seq.sv
// per_sft_rst_seq: turns the RCC software-reset bit into a clean, minimum-width sft_rst_n
// with the kernel clock forced on around the reset window.
module per_sft_rst_seq
  import per_rst_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 2,
  parameter int MIN_RST_CYCLES  = 4,
  parameter int POST_RST_CYCLES = 2
) (
  input  logic i_clk,
  input  logic sys_rst_n,
  input  logic rcc_per_rst,
  input  logic per_ker_clk_req_in,
  output logic per_ker_clk_req,
  output logic sft_rst_n,
  output logic rst_busy,
  output logic rst_done
);
  localparam int CNT_W = cnt_w(SETTLE_CYCLES, MIN_RST_CYCLES, POST_RST_CYCLES);
  localparam logic [CNT_W-1:0] SET_LD  = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] MIN_LD  = CNT_W'(MIN_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LD = CNT_W'(POST_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sft_rst_n_q, sft_rst_n_d;
  logic             rst_busy_q, rst_busy_d;
  logic             rst_done_q, rst_done_d;
  logic             cnt_zero;
  assign cnt_zero = (cnt_q == '0);
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sft_rst_n_d = sft_rst_n_q;
    rst_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rcc_per_rst) begin
          if (SETTLE_CYCLES == 0) begin
            state_d     = ASSERT;
            cnt_d       = MIN_LD;
            sft_rst_n_d = 1'b0;
          end else begin
            state_d = CLK_REQ;
            cnt_d   = SET_LD;
          end
        end
      end
      CLK_REQ: begin
        if (cnt_zero) begin
          state_d     = ASSERT;
          cnt_d       = MIN_LD;
          sft_rst_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ASSERT: begin
        if (cnt_zero && !rcc_per_rst) begin
          state_d     = RELEASE;
          cnt_d       = POST_LD;
          sft_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_zero ? cnt_q : cnt_q - ONE;
        end
      end
      RELEASE: begin
        // A fresh request here skips the settle phase: the clock is already running.
        if (rcc_per_rst) begin
          state_d     = ASSERT;
          cnt_d       = MIN_LD;
          sft_rst_n_d = 1'b0;
        end else if (cnt_zero) begin
          state_d    = IDLE;
          rst_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        sft_rst_n_d = 1'b1;
      end
    endcase
    rst_busy_d = (state_d != IDLE);
  end
  always_ff @(posedge i_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sft_rst_n_q <= 1'b1;
      rst_busy_q  <= 1'b0;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sft_rst_n_q <= sft_rst_n_d;
      rst_busy_q  <= rst_busy_d;
      rst_done_q  <= rst_done_d;
    end
  end
  assign per_ker_clk_req = per_ker_clk_req_in | (state_q != IDLE);
  assign sft_rst_n       = sft_rst_n_q;
  assign rst_busy        = rst_busy_q;
  assign rst_done        = rst_done_q;
endmodule

// File: tb/tb_per_sft_rst_seq.sv
// tb_per_sft_rst_seq: two configurations driven in parallel and checked every cycle
// against a timestamp-based model of the reset sequence.
module tb_per_sft_rst_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic clk_in = 1'b0;
  logic [1:0] ker_req, sft_n, busy, done;
  int cmp = 0;
  int err = 0;
  int edge_n = 0;
  int s_c[2] = '{2, 0};
  int m_c[2] = '{4, 1};
  int p_c[2] = '{2, 2};
  bit act[2];
  bit done_m[2];
  int a_t[2];
  int rel_t[2];

  always #5 clk = ~clk;

  per_sft_rst_seq d0 (
    .i_clk(clk), .sys_rst_n(rst_n), .rcc_per_rst(req), .per_ker_clk_req_in(clk_in),
    .per_ker_clk_req(ker_req[0]), .sft_rst_n(sft_n[0]), .rst_busy(busy[0]), .rst_done(done[0])
  );
  per_sft_rst_seq #(.SETTLE_CYCLES(0), .MIN_RST_CYCLES(1), .POST_RST_CYCLES(2)) d1 (
    .i_clk(clk), .sys_rst_n(rst_n), .rcc_per_rst(req), .per_ker_clk_req_in(clk_in),
    .per_ker_clk_req(ker_req[1]), .sft_rst_n(sft_n[1]), .rst_busy(busy[1]), .rst_done(done[1])
  );

  task automatic chk(input string name, input logic got, input logic exp);
    cmp++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, edge_n, got, exp);
    end
  endtask

  // Model: a sequence starts at edge e, reset falls at e+S, rises at the first edge
  // at least M after the fall with the request low, and the sequence ends P edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 0; done_m[i] = 0; a_t[i] = 0; rel_t[i] = -1;
      end
    end else begin
      edge_n++;
      for (int i = 0; i < 2; i++) begin
        done_m[i] = 0;
        if (!act[i]) begin
          if (req) begin act[i] = 1; a_t[i] = edge_n + s_c[i]; rel_t[i] = -1; end
        end else if (rel_t[i] < 0) begin
          if (edge_n >= a_t[i] + m_c[i] && !req) rel_t[i] = edge_n;
        end else if (req) begin
          a_t[i] = edge_n; rel_t[i] = -1;
        end else if (edge_n >= rel_t[i] + p_c[i]) begin
          act[i] = 0; done_m[i] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d ker_req", i), ker_req[i], clk_in | act[i]);
      chk($sformatf("d%0d sft_rst_n", i), sft_n[i], !(act[i] && edge_n >= a_t[i] && rel_t[i] < 0));
      chk($sformatf("d%0d rst_busy", i), busy[i], act[i]);
      chk($sformatf("d%0d rst_done", i), done[i], done_m[i]);
    end
  end

  task automatic wait_edge(input int e);
    int n = 0;
    while (edge_n < e && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (edge_n < e) begin
      err++;
      $display("FAIL wait_edge: reached edge %0d, needed %0d", edge_n, e);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_edge(9);  #2 req = 1'b1;
    wait_edge(10);
    chk("pulse ker_req on", ker_req[0], 1'b1);
    chk("s0 sft low at once", sft_n[1], 1'b0);
    #2 req = 1'b0;
    wait_edge(11);
    chk("pulse sft high in settle", sft_n[0], 1'b1);
    chk("s0 sft one cycle", sft_n[1], 1'b1);
    wait_edge(12); chk("pulse sft falls", sft_n[0], 1'b0);
    wait_edge(13); chk("s0 done", done[1], 1'b1);
    wait_edge(15); chk("pulse sft still low", sft_n[0], 1'b0);
    wait_edge(16); chk("pulse sft rises", sft_n[0], 1'b1);
    wait_edge(17);
    chk("pulse busy in post", busy[0], 1'b1);
    chk("pulse no early done", done[0], 1'b0);
    wait_edge(18);
    chk("pulse done", done[0], 1'b1);
    chk("pulse busy off", busy[0], 1'b0);
    wait_edge(19); chk("pulse done single", done[0], 1'b0);
    wait_edge(29); #2 req = 1'b1;
    wait_edge(49); chk("held sft low", sft_n[0], 1'b0);
    #2 req = 1'b0;
    wait_edge(50); chk("held sft rises", sft_n[0], 1'b1);
    wait_edge(52); chk("held done", done[0], 1'b1);
    wait_edge(59); #2 req = 1'b1;
    wait_edge(60); #2 req = 1'b0;
    wait_edge(66); chk("rereq released", sft_n[0], 1'b1);
    #2 req = 1'b1;
    wait_edge(67);
    chk("rereq sft falls", sft_n[0], 1'b0);
    chk("rereq ker_req held", ker_req[0], 1'b1);
    #2 req = 1'b0;
    wait_edge(70); chk("rereq sft min width", sft_n[0], 1'b0);
    wait_edge(71); chk("rereq sft rises", sft_n[0], 1'b1);
    wait_edge(79); #2 req = 1'b1;
    wait_edge(80); #2 req = 1'b0;
    wait_edge(84); #2 rst_n = 1'b0;
    #1;
    chk("async sft", sft_n[0], 1'b1);
    chk("async busy", busy[0], 1'b0);
    chk("async ker_req", ker_req[0], 1'b0);
    clk_in = 1'b1;
    #1 chk("async ker_req follows in", ker_req[0], 1'b1);
    @(negedge clk);
    #2 begin rst_n = 1'b1; clk_in = 1'b0; end
    wait_edge(89); #2 req = 1'b1;
    wait_edge(90); #2 req = 1'b0;
    wait_edge(92); chk("after reset sft falls", sft_n[0], 1'b0);
    wait_edge(98); chk("after reset done", done[0], 1'b1);
    wait_edge(100);
    #2 clk_in = 1'b1;
    #1 chk("idle ker_req follows 1", ker_req[0], 1'b1);
    chk("idle busy", busy[0], 1'b0);
    clk_in = 1'b0;
    #1 chk("idle ker_req follows 0", ker_req[0], 1'b0);
    begin
      int prob = 10;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        #2;
        if (c % 25 == 0) prob = (c % 100 == 0) ? 2 : (c % 100 == 25) ? 10 : (c % 100 == 50) ? 50 : 90;
        req = ($urandom_range(99) < prob);
        clk_in = $urandom_range(1) == 1;
        if ($urandom_range(199) == 0) begin
          rst_n = 1'b0;
          #1 chk("rand async sft", sft_n[0], 1'b1);
          chk("rand async busy", busy[1], 1'b0);
          @(negedge clk);
          #2 rst_n = 1'b1;
        end
      end
    end
    @(negedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/per_sft_rst_seq.md
Name: per_sft_rst_seq

Overview:
- Upstream stage of the per-peripheral clock/reset control block. Turns the RCC software-reset register bit for one peripheral into a clean, glitch-free, minimum-width active-low `sft_rst_n`.
- Forces the peripheral kernel clock request on around the reset window, so synchronous logic inside the peripheral sees clock edges while reset is asserted and while it is released.
- Reports busy/done status back to the register file.

Parameters:
- SETTLE_CYCLES, 2: cycles the kernel clock is requested before reset asserts; 0 skips the CLK_REQ state.
- MIN_RST_CYCLES, 4: minimum cycles `sft_rst_n` stays low; must be >= 1.
- POST_RST_CYCLES, 2: cycles the clock request is held after reset release; must be >= 1.
- CNT_W, derived: $clog2(max of the three above)+1; internal counter width.

Ports:
- i_clk  input  1  bus clock of the peripheral's domain.
- sys_rst_n  input  1  asynchronous active-low reset.
- rcc_per_rst  input  1  software reset register bit, level; 1 = hold peripheral in reset.
- per_ker_clk_req_in  input  1  kernel clock request from the peripheral.
- per_ker_clk_req  output  1  per_ker_clk_req_in OR internal request; feeds the clock/reset control block.
- sft_rst_n  output  1  software reset to the clock/reset control block; driven directly by a dedicated flop.
- rst_busy  output  1  high whenever the FSM is not IDLE.
- rst_done  output  1  one-cycle pulse when the FSM returns to IDLE.

Behaviour:
- Reset values, all async under sys_rst_n=0: state=IDLE, counter=0, sft_rst_n=1, internal request=0, rst_busy=0, rst_done=0. per_ker_clk_req then equals per_ker_clk_req_in.
- Registered outputs: sft_rst_n, rst_busy and rst_done are each their own flop. No combinational decode of state drives sft_rst_n.
- Internal request = (state != IDLE). It is OR-ed combinationally with per_ker_clk_req_in.
- FSM transitions:
  - IDLE: rcc_per_rst=1 sampled -> CLK_REQ, counter loads SETTLE_CYCLES-1. If SETTLE_CYCLES=0, go directly to ASSERT: counter loads MIN_RST_CYCLES-1 and sft_rst_n goes 0 on the same edge.
  - CLK_REQ: counter decrements. At 0 -> ASSERT, sft_rst_n<=0, counter loads MIN_RST_CYCLES-1.
  - ASSERT: counter decrements, saturating at 0. Exit only when counter==0 AND rcc_per_rst==0 -> RELEASE, sft_rst_n<=1, counter loads POST_RST_CYCLES-1. While rcc_per_rst stays 1, remain in ASSERT.
  - RELEASE: counter decrements. At 0 -> IDLE with rst_done<=1 for one cycle. If rcc_per_rst=1 is sampled in RELEASE -> ASSERT directly (clock is already running), sft_rst_n<=0, counter reloads MIN_RST_CYCLES-1.
- Latency with defaults, request sampled at edge k:
  - per_ker_clk_req high after edge k.
  - sft_rst_n low after edge k+2, high after edge k+6.
  - Back in IDLE after edge k+8; rst_done high during that cycle.
- Short requests: the request is effectively latched. A pulse that drops during CLK_REQ or ASSERT still produces the full settle, minimum-width and post sequence.
- Held request: sft_rst_n stays low for as long as rcc_per_rst=1, and for at least MIN_RST_CYCLES.
- rcc_per_rst=1 in the same cycle the FSM goes RELEASE->IDLE is not possible, because a request in RELEASE takes priority. A request sampled in IDLE on the cycle rst_done is high starts a new sequence normally.
- sys_rst_n asserted mid-sequence: immediate return to reset values. sft_rst_n=1 is acceptable because the downstream block ANDs sft_rst_n with sys_rst_n.
- Illegal state encodings -> IDLE.

Decomposition:
- Shared package (per_rst_pkg): state enum (IDLE, CLK_REQ, ASSERT, RELEASE) as a 2-bit localparam set, and a CNT_W helper function.
- No sub-module. Single FSM plus down-counter.

Test Plan:
- Single-cycle rcc_per_rst pulse at edge 10, defaults -> per_ker_clk_req 1 from edge 10 to edge 18; sft_rst_n 0 exactly from edge 12 to edge 16; rst_done single pulse after edge 18; rst_busy 1 for 8 cycles.
- rcc_per_rst held for 20 cycles from edge 10 -> sft_rst_n 0 from edge 12 until the edge after the request drops; then exactly 2 RELEASE cycles; no glitches on sft_rst_n.
- Re-request during RELEASE (request at edge 17) -> sft_rst_n falls at edge 17 with no CLK_REQ phase and stays low 4 cycles; per_ker_clk_req never drops in between.
- SETTLE_CYCLES=0, MIN_RST_CYCLES=1 -> sft_rst_n low on the first edge after the request, for exactly 1 cycle; IDLE 2 cycles after release.
- sys_rst_n pulsed low mid-ASSERT -> asynchronously sft_rst_n=1, rst_busy=0, per_ker_clk_req=per_ker_clk_req_in; after release, a new request runs a full sequence.
- per_ker_clk_req_in toggling in IDLE -> per_ker_clk_req follows it combinationally; rst_busy stays 0.
